// File: rtl/gen_ser_pkg.sv
// Shared types and frame-length helper for the lane serializer.
// GEN_SER_PARITY_EN appends one even-parity bit per lane to every frame.
package gen_ser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   localparam int DEF_NLANES = 2;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CNT_W  = 4;

`ifdef GEN_SER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   function automatic int frame_len(input int width);
      return PAR_EN ? width + 1 : width;
   endfunction

endpackage

// File: rtl/gen_ser_lane.sv
// One serial lane: loads a WIDTH-bit slice and presents it LSB-first.
// Latency: bit 0 visible the cycle after load. No backpressure; the top sequences load/shift.
module gen_ser_lane
   import gen_ser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             bit_out
);

   logic [WIDTH-1:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= din;
      end else if (shift) begin
         shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
   end

   assign bit_out = shreg[0];

endmodule

// File: rtl/gen_lane_serializer.sv
// Multi-lane parallel-to-serial transmitter; GEN_SER_PARITY_EN adds a trailing parity bit per lane.
// Latency: first serial bit one cycle after accept. in_ready only in IDLE or on the final frame cycle.
module gen_lane_serializer
   import gen_ser_pkg::*;
#(
   parameter int NLANES = DEF_NLANES,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NLANES*WIDTH-1:0] in_data,
   output logic                    ser_valid,
   output logic [NLANES-1:0]       ser_data,
   output logic                    ser_last,
   output logic [CNT_W-1:0]        frame_cnt
);

   localparam int FRAME_LEN = frame_len(WIDTH);
   localparam int IDX_W     = $clog2(WIDTH + 1);

   ser_state_t        state_q, state_n;
   logic [IDX_W-1:0]  idx_q, idx_n;
   logic              last_q, last_n;
   logic              accept;
   logic              shift_en;
   logic [NLANES-1:0] lane_bit;
   logic [NLANES-1:0] par_bit;

   // last_q marks the final frame cycle, which is also where the next word may be taken
   assign in_ready = ~rst & ((state_q == IDLE) | last_q);
   assign accept   = in_valid & in_ready;
   assign shift_en = (state_q == SHIFT) & ~accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         last_q  <= last_n;
      end
   end

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      if (accept) begin
         state_n = SHIFT;
         idx_n   = '0;
      end else begin
         case (state_q)
            SHIFT: begin
               if (idx_q == IDX_W'(WIDTH - 1)) begin
                  state_n = PAR_EN ? PARITY : IDLE;
               end else begin
                  idx_n = idx_q + IDX_W'(1);
               end
            end
            PARITY:  state_n = IDLE;
            default: state_n = state_q;
         endcase
      end
      last_n = (state_n == PARITY) |
               ((state_n == SHIFT) & (idx_n == IDX_W'(FRAME_LEN - 1)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (last_q) begin
         frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < NLANES; i++) begin : lane_gen
      gen_ser_lane #(
         .WIDTH(WIDTH)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .load   (accept),
         .shift  (shift_en),
         .din    (in_data[i*WIDTH +: WIDTH]),
         .bit_out(lane_bit[i])
      );

      if (PAR_EN) begin : par_gen
         logic par_q;
         // folds in each bit as it goes out, so it is complete by the PARITY cycle
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               par_q <= 1'b0;
            end else if (accept) begin
               par_q <= 1'b0;
            end else if (state_q == SHIFT) begin
               par_q <= par_q ^ lane_bit[i];
            end
         end
         assign par_bit[i] = par_q;
      end else begin : nopar_gen
         assign par_bit[i] = 1'b0;
      end
   end

   assign ser_valid = (state_q != IDLE);
   assign ser_last  = last_q;
   assign ser_data  = (state_q == SHIFT)  ? lane_bit :
                      (state_q == PARITY) ? par_bit  : '0;

endmodule

// File: tb/tb_gen_lane_serializer.sv
// Bench for gen_lane_serializer (NLANES=2, WIDTH=8, CNT_W=2); honours GEN_SER_PARITY_EN.
module tb_gen_lane_serializer;

   localparam int NLANES = 2;
   localparam int WIDTH  = 8;
   localparam int CNT_W  = 2;
`ifdef GEN_SER_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [NLANES*WIDTH-1:0] in_data;
   logic                    ser_valid;
   logic [NLANES-1:0]       ser_data;
   logic                    ser_last;
   logic [CNT_W-1:0]        frame_cnt;

   always #5 clk = ~clk;

   gen_lane_serializer #(
      .NLANES(NLANES),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .ser_valid(ser_valid),
      .ser_data (ser_data),
      .ser_last (ser_last),
      .frame_cnt(frame_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model: each accepted word becomes a list of expected output cycles
   typedef struct packed {
      logic [NLANES-1:0] dat;
      logic              last;
   } ent_t;

   ent_t             q[$];
   logic [CNT_W-1:0] cnt_exp;

   // Observations of the DUT used by literal checks
   logic [FL-1:0]    cap0, cap1;
   int               pos, last_pos, run, max_run, busy_rdy;
   logic [CNT_W-1:0] prev_cnt;
   logic [CNT_W-1:0] cnt_hist[$];

   always @(negedge clk) begin : compare
      logic              exp_v, exp_l, exp_r;
      logic [NLANES-1:0] exp_d;
      ent_t              e;
      exp_v = 1'b0; exp_l = 1'b0; exp_r = 1'b0; exp_d = '0;
      if (rst) begin
         q.delete();
         cnt_exp = '0;
      end else begin
         exp_r = (q.size() == 0) || (q.size() == 1 && q[0].last);
         if (q.size() != 0) begin
            exp_v = 1'b1;
            exp_d = q[0].dat;
            exp_l = q[0].last;
         end
      end
      chk("ser_valid", ser_valid, exp_v);
      chk("ser_data",  ser_data,  exp_d);
      chk("ser_last",  ser_last,  exp_l);
      chk("frame_cnt", frame_cnt, cnt_exp);
      chk("in_ready",  in_ready,  exp_r);
      if (!rst) begin
         if (q.size() != 0) begin
            if (q[0].last) cnt_exp = cnt_exp + 1'b1;
            void'(q.pop_front());
         end
         if (in_valid && exp_r) begin
            for (int b = 0; b < WIDTH; b++) begin
               for (int l = 0; l < NLANES; l++) e.dat[l] = in_data[l*WIDTH + b];
               e.last = (b == FL - 1);
               q.push_back(e);
            end
`ifdef GEN_SER_PARITY_EN
            for (int l = 0; l < NLANES; l++) e.dat[l] = ^in_data[l*WIDTH +: WIDTH];
            e.last = 1'b1;
            q.push_back(e);
`endif
         end
      end

      if (rst) begin
         pos = 0; run = 0; max_run = 0; busy_rdy = 0; last_pos = -1;
         prev_cnt = '0; cnt_hist.delete(); cap0 = '0; cap1 = '0;
      end else begin
         if (ser_valid) begin
            run++;
            if (run > max_run) max_run = run;
            if (pos < FL) begin
               cap0[pos] = ser_data[0];
               cap1[pos] = ser_data[1];
            end
            if (in_ready) busy_rdy++;
            if (ser_last) begin
               last_pos = pos;
               pos = 0;
            end else begin
               pos++;
            end
         end else begin
            run = 0;
         end
         if (frame_cnt != prev_cnt) begin
            cnt_hist.push_back(frame_cnt);
            prev_cnt = frame_cnt;
         end
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds the word until the handshake edge, then scrambles in_data
   task automatic send(input logic [NLANES*WIDTH-1:0] w);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      chk("send_handshake", done, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = ~w;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CNT_W-1:0] exp_w[5];
      exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_data",  ser_data,  0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_in_ready",  in_ready,  1);
      @(posedge clk);
      #1;

      // single frame
      send(16'hA53C);
      idle(FL + 2);
      chk("single_lane0", cap0[WIDTH-1:0], 8'h3C);
      chk("single_lane1", cap1[WIDTH-1:0], 8'hA5);
      chk("single_last_pos", last_pos, FL - 1);
      chk("single_cnt", frame_cnt, 1);

      // back-to-back
      do_reset(2);
      send(16'h1234);
      send(16'hFFFF);
      send(16'h0001);
      idle(FL + 3);
      chk("b2b_contig", max_run, 3 * FL);
      chk("b2b_busy_ready", busy_rdy, 3);
      chk("b2b_cnt", frame_cnt, 3);

`ifdef GEN_SER_PARITY_EN
      do_reset(2);
      send(16'h0307);
      idle(FL + 2);
      chk("par_lane0", cap0[WIDTH], 1);
      chk("par_lane1", cap1[WIDTH], 0);
      chk("par_last_pos", last_pos, WIDTH);
`endif

      // mid-frame reset at bit 4
      do_reset(2);
      send(16'hA53C);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_ser_valid", ser_valid, 0);
      chk("mid_ser_data",  ser_data,  0);
      chk("mid_ser_last",  ser_last,  0);
      chk("mid_frame_cnt", frame_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      chk("mid_cnt_after", frame_cnt, 0);
      send(16'h00FF);
      idle(FL + 2);
      chk("mid_next_lane0", cap0[WIDTH-1:0], 8'hFF);
      chk("mid_next_lane1", cap1[WIDTH-1:0], 8'h00);
      chk("mid_next_cnt", frame_cnt, 1);

      // counter wrap
      do_reset(2);
      for (int f = 0; f < 5; f++) send(16'h0F00 + 16'(f * 17));
      idle(FL + 3);
      chk("wrap_len", cnt_hist.size(), 5);
      for (int f = 0; f < 5; f++) begin
         if (f < cnt_hist.size()) chk("wrap_seq", cnt_hist[f], exp_w[f]);
         else                     chk("wrap_seq_missing", 0, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
